// File: rtl/serial_operand_serializer.sv
// Feeds a bit-serial comparator: accepts an operand pair, clears the comparator, streams the
// bit pairs one per clock, then captures the comparator verdict and returns it by handshake.
module serial_operand_serializer #(
    parameter int unsigned W         = 16,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned RES_LAT   = 1
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,

    output logic         ser_clr,
    output logic         ser_valid,
    output logic         ser_last,
    output logic         ser_a,
    output logic         ser_b,

    input  logic         cmp_less,
    input  logic         cmp_eq,
    input  logic         cmp_greater,

    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_less,
    output logic         res_eq,
    output logic         res_greater,
    output logic         res_err
);

    localparam int unsigned CntW   = $clog2(W);
    localparam int unsigned OutBit = MSB_FIRST ? W - 1 : 0;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StWait,
        StResult
    } state_e;

    state_e          state_q;
    logic [W-1:0]    sh_a_q;
    logic [W-1:0]    sh_b_q;
    logic [CntW-1:0] cnt_q;

    logic            in_ready_q;
    logic            ser_clr_q;
    logic            ser_valid_q;
    logic            ser_last_q;
    logic            res_valid_q;
    logic            res_less_q;
    logic            res_eq_q;
    logic            res_greater_q;
    logic            res_err_q;

    logic [W-1:0]    sh_a_nxt;
    logic [W-1:0]    sh_b_nxt;
    logic [1:0]      hot_cnt;
    logic            verdict_bad;

    // The bit on the output end is consumed; the vacated end fills with zero.
    assign sh_a_nxt = MSB_FIRST ? {sh_a_q[W-2:0], 1'b0} : {1'b0, sh_a_q[W-1:1]};
    assign sh_b_nxt = MSB_FIRST ? {sh_b_q[W-2:0], 1'b0} : {1'b0, sh_b_q[W-1:1]};

    assign hot_cnt     = {1'b0, cmp_less} + {1'b0, cmp_eq} + {1'b0, cmp_greater};
    assign verdict_bad = (hot_cnt != 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sh_a_q        <= '0;
            sh_b_q        <= '0;
            cnt_q         <= '0;
            in_ready_q    <= 1'b1;
            ser_clr_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            ser_last_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_less_q    <= 1'b0;
            res_eq_q      <= 1'b0;
            res_greater_q <= 1'b0;
            res_err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sh_a_q     <= in_a;
                        sh_b_q     <= in_b;
                        cnt_q      <= CntW'(W - 1);
                        in_ready_q <= 1'b0;
                        ser_clr_q  <= 1'b1;
                        state_q    <= StClear;
                    end
                end

                StClear: begin
                    ser_clr_q   <= 1'b0;
                    ser_valid_q <= 1'b1;
                    ser_last_q  <= 1'b0;
                    state_q     <= StShift;
                end

                StShift: begin
                    sh_a_q <= sh_a_nxt;
                    sh_b_q <= sh_b_nxt;
                    if (cnt_q == '0) begin
                        ser_valid_q <= 1'b0;
                        ser_last_q  <= 1'b0;
                        if (RES_LAT == 0) begin
                            // Comparator already reflects the final pair on this edge.
                            res_less_q    <= cmp_less;
                            res_eq_q      <= cmp_eq;
                            res_greater_q <= cmp_greater;
                            res_err_q     <= verdict_bad;
                            res_valid_q   <= 1'b1;
                            state_q       <= StResult;
                        end else begin
                            state_q <= StWait;
                        end
                    end else begin
                        cnt_q      <= cnt_q - CntW'(1);
                        ser_last_q <= (cnt_q == CntW'(1));
                    end
                end

                StWait: begin
                    res_less_q    <= cmp_less;
                    res_eq_q      <= cmp_eq;
                    res_greater_q <= cmp_greater;
                    res_err_q     <= verdict_bad;
                    res_valid_q   <= 1'b1;
                    state_q       <= StResult;
                end

                StResult: begin
                    // Verdict bits are left in place after the handshake.
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    ser_clr_q   <= 1'b0;
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign ser_clr     = ser_clr_q;
    assign ser_valid   = ser_valid_q;
    assign ser_last    = ser_last_q;
    assign ser_a       = ser_valid_q & sh_a_q[OutBit];
    assign ser_b       = ser_valid_q & sh_b_q[OutBit];
    assign res_valid   = res_valid_q;
    assign res_less    = res_less_q;
    assign res_eq      = res_eq_q;
    assign res_greater = res_greater_q;
    assign res_err     = res_err_q;

endmodule
